// File: rtl/imm_encoder.sv
// RV32I instruction-word encoder: formats I/S/B/U/J from separate fields and a
// numeric immediate, with one registered result stage and saturating counters.
module imm_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      FMT_I = 3'd0,
      FMT_S = 3'd1,
      FMT_B = 3'd2,
      FMT_U = 3'd3,
      FMT_J = 3'd4
   } fmt_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        accept;
   logic        ok_is;
   logic        ok_b;
   logic        ok_j;
   logic        ok_u;
   logic        err;
   logic [31:0] word;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !rst;

   // Range checks: upper immediate bits must be a pure sign extension of the field.
   assign ok_is = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
   assign ok_b  = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
   assign ok_j  = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
   assign ok_u  = (in_imm[11:0] == '0);

   always_comb begin
      word = NOP;
      err  = 1'b1;
      case (in_fmt)
         FMT_I: begin
            err  = !ok_is;
            word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         end
         FMT_S: begin
            err  = !ok_is;
            word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         end
         FMT_B: begin
            err  = !ok_b;
            word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
         end
         FMT_U: begin
            err  = !ok_u;
            word = {in_imm[31:12], in_rd, in_opcode};
         end
         FMT_J: begin
            err  = !ok_j;
            word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
         end
         default: begin
            err  = 1'b1;
            word = NOP;
         end
      endcase
      if (err) word = NOP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_instr <= word;
         out_err   <= err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enc_cnt <= '0;
         err_cnt <= '0;
      end else if (accept) begin
         if (enc_cnt != '1) enc_cnt <= enc_cnt + CNT_W'(1);
         if (err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the encoded-word and error counters.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1: request carries a field set to encode.
REQ-005 SHALL have port in_ready  output  1: encoder accepts the request this cycle.
REQ-006 SHALL have port in_fmt  input  3: format select; 0=I, 1=S, 2=B, 3=U, 4=J, 5..7 illegal.
REQ-007 SHALL have port in_opcode  input  7: opcode field.
REQ-008 SHALL have port in_rd, in_rs1, in_rs2  input  5 each: register fields.
REQ-009 SHALL have port in_funct3  input  3: funct3 field.
REQ-010 SHALL have port in_imm  input  32: immediate as a numeric byte value, two's complement.
REQ-011 SHALL have port out_valid  output  1: out_instr/out_err hold a result.
REQ-012 SHALL have port out_ready  input  1: consumer accepts the result this cycle.
REQ-013 SHALL have port out_instr  output  32: encoded RV32I instruction word.
REQ-014 SHALL have port out_err  output  1: result is an encoding error.
REQ-015 SHALL have ports enc_cnt, err_cnt  output  CNT_W: saturating counts of accepted requests and of errors.

Function
REQ-016 SHALL accept a request on a cycle where in_valid && in_ready.
REQ-017 SHALL drive in_ready = !out_valid || out_ready, a combinational path with one output register.
REQ-018 SHALL present the result at the rising edge after acceptance, with one-cycle latency.
REQ-019 SHALL hold out_valid, out_instr and out_err stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid on out_ready unless a new request is accepted in the same cycle.
- On simultaneous accept and drain, the output register SHALL load the new result with no bubble.
REQ-021 SHALL encode the I format as:
- imm[11:0] to [31:20], rs1 to [19:15], funct3 to [14:12], rd to [11:7], opcode to [6:0].
REQ-022 SHALL encode the S format as:
- imm[11:5] to [31:25], rs2 to [24:20], rs1, funct3, imm[4:0] to [11:7], opcode.
REQ-023 SHALL encode the B format as:
- imm[12] to [31], imm[10:5] to [30:25], rs2, rs1, funct3, imm[4:1] to [11:8], imm[11] to [7], opcode.
REQ-024 SHALL encode the U format as imm[31:12] to [31:12], rd, opcode.
REQ-025 SHALL encode the J format as:
- imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12], rd, opcode.
REQ-026 SHALL flag an error by format as follows:
- I/S: in_imm[31:11] not all equal.
- B: in_imm[31:12] not all equal, or in_imm[0]=1.
- J: in_imm[31:20] not all equal, or in_imm[0]=1.
- U: in_imm[11:0] not zero.
- Illegal in_fmt: always an error.
REQ-027 SHALL, on error, set out_err=1 and out_instr=32'h0000_0013 (NOP) and still complete the handshake.
REQ-028 SHALL meet the round-trip property for every non-error result: re-extracting the immediate from out_instr under the same format equals in_imm.
REQ-029 SHALL increment enc_cnt on every accept and err_cnt on every errored accept; both saturate at all-ones with no wrap.
REQ-030 SHALL ignore in_fmt/in_imm and the other fields on cycles with no acceptance.

Reset
REQ-031 SHALL, while rst=1, force out_valid=0, out_err=0, out_instr=0, enc_cnt=0 and err_cnt=0.
REQ-032 SHALL drop any held result on reset mid-operation, with no acceptance that cycle.
REQ-033 SHALL drive in_ready=1 in the first cycle after reset release.

Verification
REQ-034 SHALL cover: I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_instr=0xFFF00093, out_err=0, one cycle later.
REQ-035 SHALL cover: B, opcode 0x63, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3; then J, opcode 0x6F, rd=0, imm=8 -> 0x0080006F.
REQ-036 SHALL cover: U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7; and U with imm=0x12345001 -> 0x00000013, out_err=1, err_cnt=1.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with in_valid=1:
- Result held stable; in_ready=0.
- Next request accepted on the drain cycle with no bubble.
- enc_cnt equals the number of handshakes.
REQ-038 SHALL cover: rst asserted while out_valid=1 and stalled -> out_valid=0, counters=0 next cycle, held word never delivered.
REQ-039 SHALL cover: CNT_W=2 with 5 accepts of illegal in_fmt=6 -> enc_cnt=err_cnt=3 (saturated).
